// File: rtl/uartin.sv
// UART 8N1 receiver with active-low valid/ready output handshake, framing-error and overrun pulses.
// Define UARTIN_MAJORITY_EN to take a 2-of-3 vote around every sample point (adds one cycle of latency).
module uartin #(
    parameter int CDIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid_n,
    input  logic       ready_n,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(CDIV);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    logic          rx_meta_reg;
    logic          rx_s_reg;
    logic          sample;
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    idx_reg, idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    data_reg, data_next;
    logic          valid_n_reg, valid_n_next;
    logic          frame_err_reg, frame_err_next;
    logic          overrun_reg, overrun_next;
    logic          bit_load;
    logic          stop_ok;
    logic          stop_bad;

`ifdef UARTIN_MAJORITY_EN
    localparam int OFS = 1;
    logic [1:0] hist_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg <= 2'b11;
        end else begin
            hist_reg <= {hist_reg[0], rx_s_reg};
        end
    end

    // Vote over rx_s at cnt-1, cnt, cnt+1; evaluated in the cnt+1 cycle.
    assign sample = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rx_s_reg) | (hist_reg[0] & rx_s_reg);
`else
    localparam int OFS = 0;
    assign sample = rx_s_reg;
`endif

    // START counts from 0 in the cycle after t0, so the mid-start point is CDIV/2-1.
    localparam logic [CW-1:0] START_PT = CW'(CDIV / 2 - 1 + OFS);
    localparam logic [CW-1:0] BIT_PT   = CW'(CDIV - 1);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        idx_next   = idx_reg;
        bit_load   = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s_reg) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == START_PT) begin
                    cnt_next   = '0;
                    state_next = sample ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_PT) begin
                    cnt_next = '0;
                    bit_load = 1'b1;
                    idx_next = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_reg == BIT_PT) begin
                    cnt_next = '0;
                    if (sample) begin
                        stop_ok    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = BRK;
                    end
                end
            end
            BRK: begin
                cnt_next = '0;
                if (rx_s_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            assign shift_next[gi] = (bit_load && idx_reg == 3'(gi)) ? sample : shift_reg[gi];
        end
    endgenerate

    // A delivery coinciding with a transfer replaces the byte and keeps valid_n low.
    always_comb begin
        data_next      = data_reg;
        valid_n_next   = valid_n_reg;
        frame_err_next = stop_bad;
        overrun_next   = 1'b0;
        if (!valid_n_reg && !ready_n) begin
            valid_n_next = 1'b1;
        end
        if (stop_ok) begin
            if (valid_n_reg || !ready_n) begin
                data_next    = shift_reg;
                valid_n_next = 1'b0;
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg   <= 1'b1;
            rx_s_reg      <= 1'b1;
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_n_reg   <= 1'b1;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            rx_meta_reg   <= rx;
            rx_s_reg      <= rx_meta_reg;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            valid_n_reg   <= valid_n_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign data      = data_reg;
    assign valid_n   = valid_n_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
endmodule

// File: tb/tb_uartin.sv
// Scoreboard bench for uartin at CDIV=16: directed frames push expected events, a negedge monitor pops them.
module tb_uartin;
    localparam int CDIV = 16;
`ifdef UARTIN_MAJORITY_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    // Pin falls in cycle P -> t0 = P+2 -> valid_n low at t0 + 8 + 9*16 + 1.
    localparam int DLY = 2 + CDIV / 2 + 9 * CDIV + 1 + LAT;
    localparam int FRAME = 10 * CDIV;

    localparam int EV_BYTE = 0;
    localparam int EV_FE   = 1;
    localparam int EV_OV   = 2;

    typedef struct {
        int         kind;
        logic [7:0] d;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready_n = 1'b1;
    logic [7:0] data;
    logic       valid_n;
    logic       frame_err;
    logic       overrun;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    bit  started = 1'b0;
    logic prev_valid_n = 1'b1;
    logic prev_ready_n = 1'b1;
    ev_t exp_q[$];

    uartin #(.CDIV(CDIV)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data(data),
        .valid_n(valid_n),
        .ready_n(ready_n),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
            $display("check %s: got %0h", name, act);
        end else begin
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d, input int at);
        ev_t e;
        e.kind = kind;
        e.d    = d;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int kind, input logic [7:0] d);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d data %02h at cycle %0d, required none", kind, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.d === d && e.cyc == cyc) begin
                n_pass++;
                $display("event kind %0d data %02h at cycle %0d", kind, d, cyc);
            end else begin
                $display("FAIL event: got kind %0d data %02h cycle %0d required kind %0d data %02h cycle %0d",
                         kind, d, cyc, e.kind, e.d, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            if (frame_err === 1'b1) check_event(EV_FE, 8'h00);
            if (overrun === 1'b1) check_event(EV_OV, 8'h00);
            if (valid_n === 1'b0 && (prev_valid_n === 1'b1 || prev_ready_n === 1'b0))
                check_event(EV_BYTE, data);
        end
        prev_valid_n = valid_n;
        prev_ready_n = ready_n;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; glitch inverts the pin for one cycle at the centre of each data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < CDIV; k++) begin
                rx = bits[j] ^ (glitch && j >= 1 && j <= 8 && k == CDIV / 2);
                tick(1);
            end
        end
        rx = 1'b1;
    endtask

    task automatic consume();
        ready_n = 1'b0;
        tick(1);
        ready_n = 1'b1;
    endtask

    task automatic drained(input string name);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int p;
        tick(3);
        rst = 1'b0;
        started = 1'b1;
        check("reset_data", data, 8'h00);
        check("reset_valid_n", valid_n, 1'b1);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        tick(5);

        // Single byte with exact latency.
        p = cyc;
        push(EV_BYTE, 8'h41, p + DLY);
        send_frame(8'h41, 1'b1, 1'b0);
        tick(20);
        drained("single_drained");
        check("single_held", {23'd0, valid_n, data}, {23'd0, 1'b0, 8'h41});
        consume();
        check("single_consumed", valid_n, 1'b1);

        // Short low glitch in idle must be rejected.
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(40);
        check("glitch_valid_n", valid_n, 1'b1);
        drained("glitch_drained");

        // Framing error followed by a long break, then a clean frame.
        p = cyc;
        push(EV_FE, 8'h00, p + DLY);
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        tick(40 * CDIV);
        rx = 1'b1;
        tick(2 * CDIV);
        check("break_valid_n", valid_n, 1'b1);
        p = cyc;
        push(EV_BYTE, 8'h0F, p + DLY);
        send_frame(8'h0F, 1'b1, 1'b0);
        tick(20);
        drained("frame_drained");
        check("frame_next_data", data, 8'h0F);
        consume();

        // Back-to-back with no consumer: second byte overruns.
        p = cyc;
        push(EV_BYTE, 8'hA5, p + DLY);
        push(EV_OV, 8'h00, p + FRAME + DLY);
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        tick(20);
        drained("overrun_drained");
        check("overrun_data_kept", {23'd0, valid_n, data}, {23'd0, 1'b0, 8'hA5});
        consume();

        // Same pair, ready_n low exactly on the second delivery edge.
        p = cyc;
        push(EV_BYTE, 8'hA5, p + DLY);
        push(EV_BYTE, 8'h5A, p + FRAME + DLY);
        fork
            begin
                send_frame(8'hA5, 1'b1, 1'b0);
                send_frame(8'h5A, 1'b1, 1'b0);
            end
            begin
                tick(FRAME + DLY - 1);
                ready_n = 1'b0;
                tick(1);
                ready_n = 1'b1;
            end
        join
        tick(20);
        drained("concurrent_drained");
        check("concurrent_data", {23'd0, valid_n, data}, {23'd0, 1'b0, 8'h5A});

        // Reset during data bit 4 of an 8'hF0 frame, with 8'h5A still pending.
        rx = 1'b0;
        tick(5 * CDIV);
        rx = 1'b1;
        tick(CDIV / 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midreset_data", data, 8'h00);
        check("midreset_valid_n", valid_n, 1'b1);
        tick(FRAME);
        drained("midreset_drained");
        p = cyc;
        push(EV_BYTE, 8'hC3, p + DLY);
        send_frame(8'hC3, 1'b1, 1'b0);
        tick(20);
        drained("after_reset_drained");
        check("after_reset_data", data, 8'hC3);
        consume();

`ifdef UARTIN_MAJORITY_EN
        p = cyc;
        push(EV_BYTE, 8'h96, p + DLY);
        send_frame(8'h96, 1'b1, 1'b1);
        tick(20);
        drained("majority_drained");
        check("majority_data", data, 8'h96);
        consume();
`endif

        tick(10);
        drained("final_drained");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
